// File: rtl/nv_nvdla_cacc_pkg.sv
// Shared definitions for the CACC calc lanes: rounding encoding and signed range helpers.
package nv_nvdla_cacc_pkg;

  typedef enum logic {
    RND_HALF_AWAY = 1'b0,
    RND_FLOOR     = 1'b1
  } rnd_mode_e;

  // Largest positive value of a w-bit signed number, zero-extended to 64 bits.
  function automatic logic [63:0] smax(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative value of a w-bit signed number, sign-extended to 64 bits.
  function automatic logic [63:0] smin(input int w);
    return ~smax(w);
  endfunction

endpackage

// File: rtl/nv_nvdla_cacc_calc_lane_cvt.sv
// Per-lane combinational convert: saturate the raw sum to the partial-sum width,
// then shift, round and saturate it to the final output width.
module nv_nvdla_cacc_calc_lane_cvt
  import nv_nvdla_cacc_pkg::*;
#(
  parameter int PSUM_W = 34,
  parameter int OUT_W  = 32,
  parameter int SFT_W  = 5
) (
  input  logic [PSUM_W:0]   sum,
  input  logic [SFT_W-1:0]  truncate,
  input  logic              rnd_mode,
  output logic [PSUM_W-1:0] psat,
  output logic [OUT_W-1:0]  fdata,
  output logic              fsat
);

  localparam logic [PSUM_W-1:0]   PMAX   = PSUM_W'(smax(PSUM_W));
  localparam logic [PSUM_W-1:0]   PMIN   = PSUM_W'(smin(PSUM_W));
  localparam logic signed [PSUM_W:0] OMAX_X = (PSUM_W+1)'(smax(OUT_W));
  localparam logic signed [PSUM_W:0] OMIN_X = (PSUM_W+1)'(smin(OUT_W));
  localparam logic [OUT_W-1:0]    OMAX   = OUT_W'(smax(OUT_W));
  localparam logic [OUT_W-1:0]    OMIN   = OUT_W'(smin(OUT_W));

  logic              sign;
  logic [PSUM_W-1:0] shifted;
  logic [PSUM_W-1:0] lo_mask;
  logic              guide;
  logic              stick;
  logic              point5;
  logic [PSUM_W:0]   rnd;

  // Saturate, shift, round half away from zero (or floor), saturate to OUT_W.
  always_comb begin
    sign    = sum[PSUM_W];
    psat    = (sum[PSUM_W] != sum[PSUM_W-1]) ? (sign ? PMIN : PMAX) : sum[PSUM_W-1:0];
    shifted = $signed(psat) >>> truncate;
    // lo_mask covers exactly the shifted-out bits; its top bit is the guide,
    // the rest form the sticky. A zero shift gives an empty mask.
    lo_mask = (PSUM_W'(1) << truncate) - PSUM_W'(1);
    guide   = |(psat & (lo_mask ^ (lo_mask >> 1)));
    stick   = |(psat & (lo_mask >> 1));
    point5  = (rnd_mode_e'(rnd_mode) == RND_HALF_AWAY) & guide & (~psat[PSUM_W-1] | stick);
    rnd     = {shifted[PSUM_W-1], shifted} + (PSUM_W+1)'(point5);
    fsat    = 1'b0;
    fdata   = rnd[OUT_W-1:0];
    if ($signed(rnd) > OMAX_X) begin
      fdata = OMAX;
      fsat  = 1'b1;
    end else if ($signed(rnd) < OMIN_X) begin
      fdata = OMIN;
      fsat  = 1'b1;
    end
  end

endmodule

// File: rtl/nv_nvdla_cacc_calc_lanes.sv
// Multi-lane CACC accumulate/convert: 2-stage valid/ready pipe (S1 sum register,
// output register), per-lane convert instances and a saturating sat-event counter.
module nv_nvdla_cacc_calc_lanes
  import nv_nvdla_cacc_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int IN_W   = 22,
  parameter int PSUM_W = 34,
  parameter int OUT_W  = 32,
  parameter int SFT_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rstn,
  input  logic [SFT_W-1:0]          cfg_truncate,
  input  logic                      cfg_rnd_mode,
  input  logic                      cfg_sat_clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sel,
  input  logic [LANES*IN_W-1:0]     in_data,
  input  logic [LANES*PSUM_W-1:0]   in_op,
  input  logic                      in_op_valid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_final,
  output logic [LANES*PSUM_W-1:0]   out_partial_data,
  output logic [LANES*OUT_W-1:0]    out_final_data,
  output logic [LANES-1:0]          out_final_sat,
  output logic [CNT_W-1:0]          sat_cnt
);

  localparam int STAGES = 2;
  localparam int PC_W   = $clog2(LANES + 1);
  localparam int CW     = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'({CNT_W{1'b1}});

  logic [STAGES:1]                 vld_pipe;
  logic                            s1_vld;
  logic                            adv;
  logic                            in_acc;
  logic                            s2_xfer;

  logic [LANES-1:0][IN_W-1:0]      in_d;
  logic [LANES-1:0][PSUM_W-1:0]    in_o;
  logic [LANES-1:0][PSUM_W:0]      in_sum;
  logic [LANES-1:0][PSUM_W:0]      s1_sum;
  logic                            s1_sel;

  logic [LANES-1:0][PSUM_W-1:0]    cvt_psat;
  logic [LANES-1:0][OUT_W-1:0]     cvt_fdata;
  logic [LANES-1:0]                cvt_fsat;

  logic [LANES-1:0][PSUM_W-1:0]    out_pdat_q;
  logic [LANES-1:0][OUT_W-1:0]     out_fdat_q;

  logic [PC_W-1:0]                 sat_pop;
  logic [CW-1:0]                   cnt_sum;
  logic                            cnt_inc;

  assign s1_vld    = vld_pipe[1];
  assign out_valid = vld_pipe[2];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = ~s1_vld | adv;
  assign in_acc    = in_valid & in_ready;
  assign s2_xfer   = s1_vld & adv;

  assign in_d = in_data;
  assign in_o = in_op;

  assign out_partial_data = out_pdat_q;
  assign out_final_data   = out_fdat_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    // Operand is dropped on the first kernel pass; both terms widened by one bit.
    assign in_sum[i] = {{(PSUM_W+1-IN_W){in_d[i][IN_W-1]}}, in_d[i]}
                     + (in_op_valid ? {in_o[i][PSUM_W-1], in_o[i]} : '0);

    nv_nvdla_cacc_calc_lane_cvt #(
      .PSUM_W (PSUM_W),
      .OUT_W  (OUT_W),
      .SFT_W  (SFT_W)
    ) u_cvt (
      .sum      (s1_sum[i]),
      .truncate (cfg_truncate),
      .rnd_mode (cfg_rnd_mode),
      .psat     (cvt_psat[i]),
      .fdata    (cvt_fdata[i]),
      .fsat     (cvt_fsat[i])
    );
  end

  // Valid bits: S1 refills whenever it can accept, output reg whenever it may advance.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      vld_pipe <= '0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (adv)      vld_pipe[2] <= vld_pipe[1];
    end
  end

  // Output beat type and saturation flags; partial beats clear the flags.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      out_final     <= 1'b0;
      out_final_sat <= '0;
    end else if (s2_xfer) begin
      out_final     <= s1_sel;
      out_final_sat <= s1_sel ? cvt_fsat : '0;
    end
  end

  // Datapath registers carry no reset; they are only read under a valid bit.
  always_ff @(posedge nvdla_core_clk) begin
    if (in_acc) begin
      s1_sum <= in_sum;
      s1_sel <= in_sel;
    end
    if (s2_xfer) begin
      if (s1_sel) out_fdat_q <= cvt_fdata;
      else        out_pdat_q <= cvt_psat;
    end
  end

  // Popcount of saturated lanes on the beat currently being consumed.
  always_comb begin
    sat_pop = '0;
    for (int i = 0; i < LANES; i++) sat_pop = sat_pop + PC_W'(out_final_sat[i]);
    cnt_sum = CW'(sat_cnt) + CW'(sat_pop);
    cnt_inc = out_valid & out_ready & out_final;
  end

  // Saturating event counter; a clear pulse overrides a same-cycle increment.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      sat_cnt <= '0;
    end else if (cfg_sat_clr) begin
      sat_cnt <= '0;
    end else if (cnt_inc) begin
      sat_cnt <= (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

endmodule
